// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer slice.
//   key_state_e             debouncer FSM state encoding (2-bit)
//   key_width()             key bus width for a given N (2**N)
//   DEFAULT_DEBOUNCE_CYCLES default stability window (1 ms at 50 MHz)
//   DEFAULT_REPEAT_CYCLES   default auto-repeat period (0.5 s at 50 MHz)
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25_000_000;

  function automatic int unsigned key_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset, clears both stages to 0
//   d_i   asynchronous input bits
//   q_o   synchronised output bits (two clk edges of latency)
module key_sync_2ff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_onehot_debouncer.sv
// Debouncer for a bank of 2**N push-buttons feeding the one-hot encoder.
// Raw keys are optionally inverted, synchronised, and a pattern is accepted
// once it has been seen unchanged for DEBOUNCE_CYCLES samples. Multi-key
// chords are passed through untouched; the encoder flags them.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   keys_raw    asynchronous raw key pins
//   key_vec     last accepted pressed pattern (active-high), 0 when released
//   key_strobe  one-cycle pulse when key_vec takes a new nonzero pattern
//   key_busy    high whenever the FSM is not in IDLE
// Build option:
//   KEY_AUTOREPEAT_EN  adds REPEAT_CYCLES; key_strobe re-pulses every
//                      REPEAT_CYCLES cycles while a pattern stays held.
module key_onehot_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N               = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [key_width(N)-1:0] keys_raw,
  output logic [key_width(N)-1:0] key_vec,
  output logic                   key_strobe,
  output logic                   key_busy
);

  localparam int unsigned W  = key_width(N);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [W-1:0]  keys_in;
  logic [W-1:0]  s;
  logic [W-1:0]  p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable;
  key_state_e    state_q, state_d;
  logic [W-1:0]  vec_q, vec_d;
  logic          accept;
  logic          rep_fire;
  logic          strobe_q;

  // Normalise to active-high before synchronising so reset value 0 = released.
  assign keys_in = ACTIVE_LOW ? ~keys_raw : keys_raw;

  key_sync_2ff #(
    .WIDTH (W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (keys_in),
    .q_o (s)
  );

  assign stable = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s != '0) state_d = PRESS;
      end
      PRESS: begin
        if (s == '0) begin
          state_d = IDLE;
        end else if (stable) begin
          state_d = HELD;
          vec_d   = s;
          accept  = 1'b1;
        end
      end
      HELD: begin
        if (s == vec_q) begin
          state_d = HELD;
        end else if (s == '0) begin
          state_d = RELEASE;
        end else begin
          state_d = PRESS;
        end
      end
      RELEASE: begin
        if (s != '0) begin
          // Key reappearing unchanged is release bounce: resume without a strobe.
          state_d = (s == vec_q) ? HELD : PRESS;
        end else if (stable) begin
          state_d = IDLE;
          vec_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any sample change or state change restarts the stability window.
  always_comb begin
    cnt_d = cnt_q;
    if ((s != p_q) || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;

  // Counts only while HELD with the accepted pattern; anything else clears it.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if ((state_q == HELD) && (s == vec_q)) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      vec_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      p_q      <= s;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      vec_q    <= vec_d;
      strobe_q <= accept | rep_fire;
    end
  end

  assign key_vec    = vec_q;
  assign key_strobe = strobe_q;
  assign key_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_key_onehot_debouncer.sv
// Self-checking bench for key_onehot_debouncer (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Directed scenarios plus a randomized phase, all compared every cycle
// against a timestamp-based reference model of the debounce rules.
module tb_key_onehot_debouncer;

  localparam int unsigned DB  = 4;
  localparam int unsigned REP = 10;
  localparam int          LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys_raw = 8'hFF;
  logic [7:0] key_vec;
  logic       key_strobe;
  logic       key_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_onehot_debouncer #(
    .N               (3),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1'b1)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES   (REP)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .key_vec    (key_vec),
    .key_strobe (key_strobe),
    .key_busy   (key_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 pressing, 2 held, 3 releasing.
  // Stability is judged from the edge index of the last sample change or
  // mode change rather than from a counter.
  int         cyc_now = 0;
  int         md = 0, nmd;
  int         t_clr = 0, t_rep = 0, e;
  bit         stable;
  logic [7:0] m_s1 = '0, m_s = '0, m_p = '0, m_vec = '0, nvec;
  logic       m_stb = 1'b0, nstb;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md = 0; m_s1 = '0; m_s = '0; m_p = '0; m_vec = '0; m_stb = 1'b0;
      t_clr = cyc_now; t_rep = cyc_now;
    end else begin
      e      = cyc_now;
      stable = ((e - 1 - t_clr) >= int'(DB));
      nmd    = md;
      nvec   = m_vec;
      nstb   = 1'b0;
      case (md)
        0: if (m_s != 0) nmd = 1;
        1: begin
          if (m_s == 0) nmd = 0;
          else if (stable) begin nmd = 2; nvec = m_s; nstb = 1'b1; end
        end
        2: begin
          if (m_s == m_vec) begin
`ifdef KEY_AUTOREPEAT_EN
            if (e - t_rep == int'(REP)) begin nstb = 1'b1; t_rep = e; end
`endif
          end else if (m_s == 0) nmd = 3;
          else nmd = 1;
        end
        default: begin
          if (m_s != 0) nmd = (m_s == m_vec) ? 2 : 1;
          else if (stable) begin nmd = 0; nvec = '0; end
        end
      endcase
      if (nmd == 2 && md != 2) t_rep = e;
      if (m_s != m_p || nmd != md) t_clr = e;
      md    = nmd;
      m_vec = nvec;
      m_stb = nstb;
      m_p   = m_s;
      m_s   = m_s1;
      m_s1  = ~keys_raw;
    end
  end

  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    check("model_vec", key_vec, m_vec);
    check("model_strobe", key_strobe, m_stb);
    check("model_busy", key_busy, (md != 0));
    check("strobe_gap", prev_stb & key_strobe, 0);
    prev_stb = key_strobe;
  end

  task automatic wait_strobe(input int max, output int lat);
    lat = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_clear(input int max, output int lat, output int nstb);
    lat  = -1;
    nstb = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_strobe) nstb++;
      if (key_vec == 8'h00) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (key_strobe) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, k;
    logic [7:0] pat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_vec", key_vec, 8'h00);
    check("reset_strobe", key_strobe, 0);
    check("reset_busy", key_busy, 0);

    // Clean press and release of key1.
    keys_raw = 8'hFD;
    wait_strobe(30, lat);
    check("press_latency", lat, LAT);
    check("press_vec", key_vec, 8'h02);
    count_strobes(5, n);
    check("press_single_strobe", n, 0);
    keys_raw = 8'hFF;
    wait_clear(30, lat, n);
    check("release_latency", lat, LAT);
    check("release_no_strobe", n, 0);
    count_strobes(3, n);
    check("release_idle", key_busy, 0);

    // Bit0 bouncing every 2 cycles, then settling pressed.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      keys_raw = (i % 2 == 0) ? 8'hFE : 8'hFF;
      count_strobes(2, n);
      k += n;
    end
    keys_raw = 8'hFE;
    count_strobes(15, n);
    check("bounce_one_strobe", k + n, 1);
    check("bounce_vec", key_vec, 8'h01);
    keys_raw = 8'hFF;
    count_strobes(12, n);

    // Short glitch from idle is rejected.
    keys_raw = 8'hFE;
    count_strobes(3, k);
    keys_raw = 8'hFF;
    count_strobes(12, n);
    check("glitch_no_strobe", k + n, 0);
    check("glitch_vec", key_vec, 8'h00);
    check("glitch_idle", key_busy, 0);

    // Release bounce while key4 is held.
    keys_raw = 8'hEF;
    wait_strobe(30, lat);
    check("rb_latency", lat, LAT);
    keys_raw = 8'hFF;
    count_strobes(2, k);
    keys_raw = 8'hEF;
    count_strobes(8, n);
    check("rb_no_strobe", k + n, 0);
    check("rb_vec", key_vec, 8'h10);
    check("rb_busy", key_busy, 1);
    keys_raw = 8'hFF;
    count_strobes(12, n);

    // Chord: key0 then key0+key3.
    keys_raw = 8'hFE;
    wait_strobe(30, lat);
    check("chord_first_latency", lat, LAT);
    check("chord_first_vec", key_vec, 8'h01);
    keys_raw = 8'hF6;
    wait_strobe(30, lat);
    check("chord_second_latency", lat, LAT);
    check("chord_second_vec", key_vec, 8'h09);

    // Reset in the middle of holding key2.
    keys_raw = 8'hFB;
    wait_strobe(30, lat);
    check("pre_reset_vec", key_vec, 8'h04);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_vec", key_vec, 8'h00);
    check("midreset_strobe", key_strobe, 0);
    check("midreset_busy", key_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_strobe(30, lat);
    check("post_reset_latency", lat, LAT);
    check("post_reset_vec", key_vec, 8'h04);
    keys_raw = 8'hFF;
    count_strobes(12, n);

    // Randomized patterns checked by the model each cycle.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3) pat = 8'h00;
      else if (k < 8) pat = 8'h01 << $urandom_range(0, 7);
      else pat = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
      keys_raw = ~pat;
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    keys_raw = 8'hFF;
    count_strobes(15, n);
    check("random_end_vec", key_vec, 8'h00);

`ifdef KEY_AUTOREPEAT_EN
    keys_raw = 8'hDF;
    wait_strobe(30, lat);
    check("rep_accept_latency", lat, LAT);
    check("rep_vec", key_vec, 8'h20);
    count_strobes(35, n);
    check("rep_count", n, 3);
    keys_raw = 8'hFF;
    count_strobes(15, n);
    check("rep_none_after_release", n, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
